// File: rtl/coupled_phase_oscillator.sv
// Clocked phase-accumulator spin node: per-port mismatch counts over a fixed window
// are weighted and summed, and the sum retunes the phase increment.
module coupled_phase_oscillator #(
    parameter int PORTS     = 16,
    parameter int PHASE_W   = 10,
    parameter int WIN_W     = 6,
    parameter int BASE_STEP = 8,
    parameter int ADJ_SHIFT = 4,
    parameter int RESET     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [3*PORTS-1:0]   coupling_weights,
    input  logic [PORTS-1:0]     coupling_inputs,
    output logic                 out,
    output logic [PHASE_W-1:0]   phase,
    output logic [PHASE_W-2:0]   step,
    output logic                 window_done
);

    localparam int KW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int AW = WIN_W + 3 + $clog2(PORTS);
    localparam int SW = ((AW > PHASE_W) ? AW : PHASE_W) + 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACC   = 2'd1;
    localparam logic [1:0] ST_APPLY = 2'd2;

    localparam logic [PHASE_W-1:0]    PHASE_RST  = (RESET != 0) ? {1'b1, {(PHASE_W-1){1'b0}}} : {PHASE_W{1'b0}};
    localparam logic [PHASE_W-2:0]    STEP_RST   = (PHASE_W-1)'(BASE_STEP);
    localparam logic signed [SW-1:0]  BASE_S     = SW'(BASE_STEP);
    localparam logic signed [SW-1:0]  ONE_S      = SW'(1);
    localparam logic signed [SW-1:0]  STEP_MAX_S = SW'((2 ** (PHASE_W - 1)) - 1);
    localparam logic [KW-1:0]         K_LAST     = KW'(PORTS - 1);

    // The window must be long enough for ACC and APPLY to finish before it closes again.
    generate
        if ((2 ** WIN_W) < (PORTS + 2)) begin : g_bad_window
            $error("coupled_phase_oscillator: 2**WIN_W must be at least PORTS+2");
        end
    endgenerate

    function automatic logic signed [AW-1:0] weighted_term(input logic [2:0] code,
                                                           input logic [WIN_W:0] cnt);
        logic signed [AW-1:0] mag;
        mag = $signed({{(AW-WIN_W-1){1'b0}}, cnt});
        case (code)
            3'b000:  weighted_term = -(mag <<< 1);
            3'b001:  weighted_term = -mag;
            3'b011:  weighted_term = mag;
            3'b100:  weighted_term = mag <<< 1;
            default: weighted_term = {AW{1'b0}};
        endcase
    endfunction

    logic [PHASE_W-1:0]   phase_r;
    logic [PHASE_W-2:0]   step_r;
    logic                 done_r;
    logic [1:0]           state_r;
    logic [KW-1:0]        k_r;
    logic signed [AW-1:0] acc_r;
    logic [WIN_W-1:0]     win_cnt_r;
    logic [WIN_W:0]       mm_r [PORTS];
    logic [WIN_W:0]       sh_r [PORTS];

    logic                 win_end_s;
    logic [PORTS-1:0]     mismatch_s;
    logic signed [AW-1:0] term_s;
    logic signed [AW-1:0] adj_s;
    logic signed [SW-1:0] sum_s;
    logic [PHASE_W-2:0]   next_step_s;

    assign out         = phase_r[PHASE_W-1];
    assign phase       = phase_r;
    assign step        = step_r;
    assign window_done = done_r;

    assign win_end_s  = en && (win_cnt_r == {WIN_W{1'b1}});
    assign mismatch_s = coupling_inputs ^ {PORTS{phase_r[PHASE_W-1]}};

    // Weighted contribution of the port indexed by k and the clamped next step.
    always_comb begin
        term_s = weighted_term(coupling_weights[3*int'(k_r) +: 3], sh_r[k_r]);
        adj_s  = acc_r >>> ADJ_SHIFT;
        sum_s  = BASE_S + {{(SW-AW){adj_s[AW-1]}}, adj_s};
        if (sum_s < ONE_S) begin
            next_step_s = (PHASE_W-1)'(1);
        end else if (sum_s > STEP_MAX_S) begin
            next_step_s = STEP_MAX_S[PHASE_W-2:0];
        end else begin
            next_step_s = sum_s[PHASE_W-2:0];
        end
    end

    // Phase accumulator and window counter, both frozen while en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r   <= PHASE_RST;
            win_cnt_r <= {WIN_W{1'b0}};
        end else if (en) begin
            phase_r   <= phase_r + {1'b0, step_r};
            win_cnt_r <= win_cnt_r + WIN_W'(1);
        end
    end

    // Mismatch counters; the closing cycle's mismatch lands in the shadow copy.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PORTS; i++) begin
            if (rst) begin
                mm_r[i] <= {(WIN_W+1){1'b0}};
                sh_r[i] <= {(WIN_W+1){1'b0}};
            end else if (win_end_s) begin
                sh_r[i] <= mm_r[i] + (WIN_W+1)'(mismatch_s[i]);
                mm_r[i] <= {(WIN_W+1){1'b0}};
            end else if (en) begin
                mm_r[i] <= mm_r[i] + (WIN_W+1)'(mismatch_s[i]);
            end
        end
    end

    // Retune FSM: accumulate one port per cycle, then load the clamped step.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            k_r     <= {KW{1'b0}};
            acc_r   <= {AW{1'b0}};
            step_r  <= STEP_RST;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (win_end_s) begin
                        state_r <= ST_ACC;
                        k_r     <= {KW{1'b0}};
                        acc_r   <= {AW{1'b0}};
                    end
                end
                ST_ACC: begin
                    acc_r <= acc_r + term_s;
                    if (k_r == K_LAST) begin
                        state_r <= ST_APPLY;
                    end else begin
                        k_r <= k_r + KW'(1);
                    end
                end
                ST_APPLY: begin
                    step_r  <= next_step_s;
                    done_r  <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/coupled_phase_oscillator.md
# coupled_phase_oscillator

Synchronous, parametrised successor to the free-running ring oscillator cell. It replaces gate-delay propagation with a clocked phase accumulator. Per-port coupling measures phase match by counting output mismatches over a fixed window, then retunes the accumulator step, so coupling acts on measured phase agreement rather than on instantaneous wave-front position. One instance forms one spin node of the clocked Ising array, and instances couple all-to-all through `coupling_inputs`.

## Interface
- `PORTS` default 16: number of coupled inputs.
- `PHASE_W` default 10: phase accumulator width; `out` is the phase MSB.
- `WIN_W` default 6: mismatch window is 2^WIN_W enabled cycles. 2^WIN_W must be at least PORTS+2; violation is an elaboration error.
- `BASE_STEP` default 8: uncoupled phase increment per cycle, range 1..2^(PHASE_W-2)-1.
- `ADJ_SHIFT` default 4: arithmetic right shift applied to the weighted mismatch sum.
- `RESET` default 0: reset value of `out`; phase resets to RESET<<(PHASE_W-1).

Ports:
- `clk` input 1: single clock; all state on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: phase/window advance enable.
- `coupling_weights` input 3*PORTS: 3 bits per port, port i at [3i+2:3i]. Encoding: 000=-2, 001=-1, 010=0, 011=+1, 100=+2; 101–111 are treated as 0.
- `coupling_inputs` input PORTS: `out` of coupled oscillators.
- `out` output 1: phase[PHASE_W-1], registered.
- `phase` output PHASE_W: current accumulator value.
- `step` output PHASE_W-1: increment currently in use.
- `window_done` output 1: one-cycle pulse, high in the cycle after a new `step` is applied.

## Operation
- Phase: on each enabled cycle, phase <= phase + step, mod 2^PHASE_W; it wraps silently. `en`=0 holds the phase, the window counter and the mismatch counters.
- Mismatch counting: on each enabled cycle, mm[i] (WIN_W+1 bits) increments when coupling_inputs[i] != out. The comparison uses the registered `out` of that cycle.
- Window: win_cnt (WIN_W bits) counts enabled cycles. On the enabled cycle with win_cnt = 2^WIN_W-1:
  - mm[i], including that cycle's mismatch, is copied to shadow sh[i];
  - mm[i] is cleared to 0;
  - win_cnt wraps to 0;
  - the FSM enters ACC.
  The next window counts immediately, with no dead cycle.
- FSM states: IDLE, ACC, APPLY.
  - IDLE: wait for window end.
  - ACC: lasts PORTS cycles, index k = 0..PORTS-1, one port per cycle. acc <= acc + w[k]*sh[k], where w[k] is the live weight decoded as a signed value. acc is cleared on entry. acc is signed, WIN_W+3+clog2(PORTS) bits, and cannot overflow. Weights must be stable during ACC.
  - APPLY: one cycle. step <= clamp(BASE_STEP + (acc >>> ADJ_SHIFT), 1, 2^(PHASE_W-1)-1). Then return to IDLE.
  - ACC and APPLY advance regardless of `en`.
- Sign convention: a positive weight with mismatch speeds this node up; a negative weight with mismatch slows it down; a matched input contributes 0.
- Window end while not IDLE cannot occur, given the parameter constraint.
- Reset, at any time including mid-ACC or APPLY, produces on the next edge:
  - phase = RESET<<(PHASE_W-1), out = RESET;
  - step = BASE_STEP;
  - mm, sh, acc, win_cnt = 0;
  - FSM in IDLE, window_done = 0.
  An in-flight accumulation is discarded. Reset overrides `en`.

## Timing
- `out`, `phase`, `step`, `window_done` are all registered, with zero combinational paths from inputs to outputs.
- Take edge W as the edge that closes a window:
  - edges W+1..W+PORTS perform ACC;
  - edge W+PORTS+1 loads the new `step` and raises `window_done` for one cycle;
  - the first phase add using the new step occurs at edge W+PORTS+2.
- With `en` held high after reset, the first window closes at edge 2^WIN_W after reset deasserts.
- Step-change latency is fixed at PORTS+1 cycles after window close and is independent of `en`.

## Test plan
All scenarios use PORTS=4, PHASE_W=10, WIN_W=6, BASE_STEP=8, ADJ_SHIFT=4, RESET=0, `en`=1.
- Reset, all weights 010 -> out=0, phase=0, step=8. `out` rises at edge 64 (phase=512) and toggles every 64 cycles. `window_done` pulses every 64 cycles and step stays 8.
- All weights 100, coupling_inputs = ~out every cycle -> sh[i]=64, acc=512, 512>>>4=32. At edge 69, step=40 and window_done=1 for exactly one cycle.
- All weights 000, inputs = ~out -> acc=-512, 8-32=-24, clamped so step=1. Weights 011 with inputs = ~out only on 32 cycles -> acc=128, step=16.
- Weights 100, inputs = out -> acc=0, step=8. Weights 111 with inputs = ~out -> treated as 0, step=8.
- `en` low for 20 cycles mid-window -> phase, out and win_cnt hold; the window close shifts by exactly 20 edges.
- `rst` asserted for one cycle during ACC (edge 66) -> next cycle: state IDLE, step=8, phase=0, no window_done pulse; the next close is at 64 edges after reset deasserts.
